// File: rtl/weighted_disparity_decimator.sv
// weighted_disparity_decimator
// Accumulates the count of unmasked pixels over each group of DEC_FACTOR mask
// columns, scales the final beat's confidence by that fraction, applies the
// confidence threshold and emits disparity x scaled confidence through a
// two-stage valid/ready pipeline.
module weighted_disparity_decimator #(
    parameter int DISP_BITS   = 5,
    parameter int CONF_BITS   = 8,
    parameter int DEC_FACTOR  = 2,
    parameter int CONF_THRESH = 0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic [DEC_FACTOR-1:0]          mask_in,
    input  logic [DISP_BITS-1:0]           disp_in,
    input  logic [CONF_BITS-1:0]           conf_in,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [DISP_BITS+CONF_BITS-1:0] disp_conf_out,
    output logic [CONF_BITS-1:0]           conf_out,
    output logic                           out_valid,
    input  logic                           out_ready
);

    localparam int CNT_W  = $clog2(DEC_FACTOR);
    localparam int ACC_W  = $clog2(DEC_FACTOR * DEC_FACTOR + 1);
    localparam int SHIFT  = $clog2(DEC_FACTOR * DEC_FACTOR);
    localparam int PROD_W = CONF_BITS + ACC_W;
    localparam int DC_W   = DISP_BITS + CONF_BITS;
    // One guard bit for the threshold and one for the borrow of the compare
    localparam int CMP_W  = CONF_BITS + 2;

    // Stage 0: group accumulator
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [ACC_W-1:0]     zeros;
    logic [ACC_W-1:0]     group_count;

    // Stage 1: completed group waiting for arithmetic
    logic                 s1_valid_q;
    logic [ACC_W-1:0]     s1_count_q;
    logic [DISP_BITS-1:0] s1_disp_q;
    logic [CONF_BITS-1:0] s1_conf_q;

    // Stage 2: output registers
    logic                 out_valid_q;
    logic [CONF_BITS-1:0] conf_q;
    logic [DC_W-1:0]      dc_q;

    // Handshake and arithmetic intermediates
    logic                 adv1, adv2;
    logic                 accept;
    logic                 last_beat;
    logic                 push;
    logic [PROD_W-1:0]    prod;
    logic [CONF_BITS-1:0] conf_scaled;
    logic [CMP_W-1:0]     thr_diff;
    logic                 below_thresh;
    logic [CONF_BITS-1:0] conf_w_d;
    logic [DC_W-1:0]      dc_d;

    // Pipeline advance conditions; input acceptance is purely combinational
    always_comb begin
        adv2      = !out_valid_q || out_ready;
        adv1      = !s1_valid_q || adv2;
        in_ready  = adv1;
        accept    = in_valid && adv1;
        last_beat = (cnt_q == CNT_W'(DEC_FACTOR - 1));
        // A flushed beat is discarded, so it can never complete a group
        push      = accept && last_beat && !flush;
    end

    // Count unmasked (zero) pixels in the current mask column
    always_comb begin
        zeros = '0;
        for (int unsigned i = 0; i < DEC_FACTOR; i++) begin
            zeros = zeros + ACC_W'(!mask_in[i]);
        end
        group_count = acc_q + zeros;
    end

    // Next-state for the accumulator: flush wins over any accepted beat
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (flush) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (accept) begin
            if (last_beat) begin
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = group_count;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Accumulator and beat counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    // Confidence scaling, threshold and disparity product on the stage-1 data
    always_comb begin
        prod         = PROD_W'(s1_conf_q) * PROD_W'(s1_count_q);
        // count <= D*D, so the shifted product always fits CONF_BITS
        conf_scaled  = CONF_BITS'(prod >> SHIFT);
        thr_diff     = CMP_W'(conf_scaled) - CMP_W'(CONF_THRESH);
        below_thresh = thr_diff[CMP_W-1];
        conf_w_d     = below_thresh ? '0 : conf_scaled;
        dc_d         = DC_W'(s1_disp_q) * DC_W'(conf_w_d);
    end

    // Stage 1: capture a completed group, release it when stage 2 advances
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q <= 1'b0;
            s1_count_q <= '0;
            s1_disp_q  <= '0;
            s1_conf_q  <= '0;
        end else if (push) begin
            s1_valid_q <= 1'b1;
            s1_count_q <= group_count;
            s1_disp_q  <= disp_in;
            s1_conf_q  <= conf_in;
        end else if (adv2) begin
            s1_valid_q <= 1'b0;
        end
    end

    // Stage 2: output registers, held while the consumer stalls
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            conf_q      <= '0;
            dc_q        <= '0;
        end else if (adv2) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                conf_q <= conf_w_d;
                dc_q   <= dc_d;
            end
        end
    end

    assign out_valid     = out_valid_q;
    assign conf_out      = conf_q;
    assign disp_conf_out = dc_q;

endmodule

// File: tb/tb_weighted_disparity_decimator.sv
// Self-checking bench for weighted_disparity_decimator: three instances
// (D=2 no threshold, D=2 threshold 100, D=4) checked against expected-result
// queues filled from constant tables and from an arithmetic reference model.
module tb_weighted_disparity_decimator;

    typedef struct {
        int conf;
        int dc;
    } exp_t;

    typedef struct {
        logic [1:0] m0;
        logic [1:0] m1;
        logic [4:0] disp;
        logic [7:0] conf;
        int         exp_conf;
        int         exp_dc;
    } vec_t;

    logic clk;
    logic reset;

    // Instance 0: D=2, no threshold
    logic        flush0, iv0, ir0, ov0, ordy0;
    logic [1:0]  mask0;
    logic [4:0]  disp0;
    logic [7:0]  confi0, confo0;
    logic [12:0] dco0;

    // Instance 1: D=2, threshold 100
    logic        flush1, iv1, ir1, ov1, ordy1;
    logic [1:0]  mask1;
    logic [4:0]  disp1;
    logic [7:0]  confi1, confo1;
    logic [12:0] dco1;

    // Instance 2: D=4, no threshold
    logic        flush2, iv2, ir2, ov2, ordy2;
    logic [3:0]  mask2;
    logic [4:0]  disp2;
    logic [7:0]  confi2, confo2;
    logic [12:0] dco2;

    int n_vec;
    int n_err;
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    logic stall0;
    vec_t tbl0[9];
    vec_t tbl1[4];

    weighted_disparity_decimator #(
        .DISP_BITS(5), .CONF_BITS(8), .DEC_FACTOR(2), .CONF_THRESH(0)
    ) u0 (
        .clk(clk), .reset(reset), .flush(flush0), .mask_in(mask0),
        .disp_in(disp0), .conf_in(confi0), .in_valid(iv0), .in_ready(ir0),
        .disp_conf_out(dco0), .conf_out(confo0), .out_valid(ov0),
        .out_ready(ordy0)
    );

    weighted_disparity_decimator #(
        .DISP_BITS(5), .CONF_BITS(8), .DEC_FACTOR(2), .CONF_THRESH(100)
    ) u1 (
        .clk(clk), .reset(reset), .flush(flush1), .mask_in(mask1),
        .disp_in(disp1), .conf_in(confi1), .in_valid(iv1), .in_ready(ir1),
        .disp_conf_out(dco1), .conf_out(confo1), .out_valid(ov1),
        .out_ready(ordy1)
    );

    weighted_disparity_decimator #(
        .DISP_BITS(5), .CONF_BITS(8), .DEC_FACTOR(4), .CONF_THRESH(0)
    ) u2 (
        .clk(clk), .reset(reset), .flush(flush2), .mask_in(mask2),
        .disp_in(disp2), .conf_in(confi2), .in_valid(iv2), .in_ready(ir2),
        .disp_conf_out(dco2), .conf_out(confo2), .out_valid(ov2),
        .out_ready(ordy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference: fraction of unmasked pixels times confidence, then threshold
    function automatic exp_t model(input int d, input int thr, input int zeros,
                                   input int disp, input int conf);
        exp_t e;
        e.conf = (conf * zeros) / (d * d);
        if (e.conf < thr) e.conf = 0;
        e.dc = disp * e.conf;
        return e;
    endfunction

    function automatic int zeros_of(input logic [7:0] m, input int w);
        int n;
        n = 0;
        for (int i = 0; i < w; i++) if (!m[i]) n++;
        return n;
    endfunction

    function automatic exp_t mk(input int c, input int d);
        exp_t e;
        e.conf = c;
        e.dc   = d;
        return e;
    endfunction

    // Output monitor, instance 0: head of queue must be presented and held
    always @(negedge clk) begin
        if (!reset) begin
            stall0 = 1'b0;
        end else begin
            if (stall0) check("hold_valid", int'(ov0), 1);
            if (ov0) begin
                if (q0.size() == 0) begin
                    check("u0_unexpected_output", 1, 0);
                end else begin
                    check("u0_conf_out", int'(confo0), q0[0].conf);
                    check("u0_disp_conf_out", int'(dco0), q0[0].dc);
                    if (ordy0) void'(q0.pop_front());
                end
            end
            stall0 = ov0 && !ordy0;
        end
    end

    // Output monitor, instance 1 (always ready)
    always @(negedge clk) begin
        if (reset && ov1) begin
            if (q1.size() == 0) begin
                check("u1_unexpected_output", 1, 0);
            end else begin
                check("u1_conf_out", int'(confo1), q1[0].conf);
                check("u1_disp_conf_out", int'(dco1), q1[0].dc);
                void'(q1.pop_front());
            end
        end
    end

    // Output monitor, instance 2 (always ready)
    always @(negedge clk) begin
        if (reset && ov2) begin
            if (q2.size() == 0) begin
                check("u2_unexpected_output", 1, 0);
            end else begin
                check("u2_conf_out", int'(confo2), q2[0].conf);
                check("u2_disp_conf_out", int'(dco2), q2[0].dc);
                void'(q2.pop_front());
            end
        end
    end

    // Present one beat to instance 0 and hold it until accepted
    task automatic beat0(input logic [1:0] m, input logic [4:0] d,
                         input logic [7:0] c, input logic fl);
        bit ok;
        mask0 = m; disp0 = d; confi0 = c; flush0 = fl; iv0 = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (ir0) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!ok) check("u0_accept_timeout", 0, 1);
        iv0 = 1'b0; flush0 = 1'b0;
    endtask

    task automatic beat1(input logic [1:0] m, input logic [4:0] d, input logic [7:0] c);
        bit ok;
        mask1 = m; disp1 = d; confi1 = c; iv1 = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (ir1) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!ok) check("u1_accept_timeout", 0, 1);
        iv1 = 1'b0;
    endtask

    task automatic beat2(input logic [3:0] m, input logic [4:0] d, input logic [7:0] c);
        bit ok;
        mask2 = m; disp2 = d; confi2 = c; iv2 = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (ir2) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!ok) check("u2_accept_timeout", 0, 1);
        iv2 = 1'b0;
    endtask

    task automatic drain_all();
        for (int i = 0; i < 300 && (q0.size() + q1.size() + q2.size()) != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check("u0_drain_remaining", q0.size(), 0);
        check("u1_drain_remaining", q1.size(), 0);
        check("u2_drain_remaining", q2.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] ma, mb;
        logic [3:0] m4[4];
        logic [4:0] d;
        logic [7:0] c;
        bit         done;
        int         z;

        n_vec = 0; n_err = 0; stall0 = 1'b0;
        reset = 1'b1;
        flush0 = 0; iv0 = 0; mask0 = '0; disp0 = '0; confi0 = '0; ordy0 = 1;
        flush1 = 0; iv1 = 0; mask1 = '0; disp1 = '0; confi1 = '0; ordy1 = 1;
        flush2 = 0; iv2 = 0; mask2 = '0; disp2 = '0; confi2 = '0; ordy2 = 1;

        tbl0[0] = '{2'b00, 2'b00, 5'd10, 8'd200, 200, 2000};
        tbl0[1] = '{2'b11, 2'b11, 5'd10, 8'd200,   0,    0};
        tbl0[2] = '{2'b01, 2'b00, 5'd10, 8'd200, 150, 1500};
        tbl0[3] = '{2'b10, 2'b10, 5'd31, 8'd255, 127, 3937};
        tbl0[4] = '{2'b00, 2'b11, 5'd7,  8'd1,     0,    0};
        tbl0[5] = '{2'b00, 2'b00, 5'd31, 8'd255, 255, 7905};
        tbl0[6] = '{2'b01, 2'b10, 5'd3,  8'd100,  50,  150};
        tbl0[7] = '{2'b11, 2'b01, 5'd17, 8'd77,   19,  323};
        tbl0[8] = '{2'b00, 2'b01, 5'd0,  8'd250, 187,    0};

        tbl1[0] = '{2'b11, 2'b10, 5'd9, 8'd200,   0,    0};
        tbl1[1] = '{2'b01, 2'b10, 5'd9, 8'd255, 127, 1143};
        tbl1[2] = '{2'b00, 2'b11, 5'd3, 8'd200, 100,  300};
        tbl1[3] = '{2'b11, 2'b00, 5'd3, 8'd199,   0,    0};

        // Reset values
        #3 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", int'(ov0), 0);
        check("rst_conf_out", int'(confo0), 0);
        check("rst_disp_conf_out", int'(dco0), 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Latency: out_valid two cycles after the final beat is accepted
        beat0(2'b00, 5'd3, 8'd7, 1'b0);
        beat0(2'b00, 5'd10, 8'd200, 1'b0);
        q0.push_back(mk(200, 2000));
        check("latency_t1_out_valid", int'(ov0), 0);
        @(posedge clk);
        #1;
        check("latency_t2_out_valid", int'(ov0), 1);

        // Table vectors, instance 0
        for (int i = 0; i < 9; i++) begin
            beat0(tbl0[i].m0, 5'($urandom), 8'($urandom), 1'b0);
            beat0(tbl0[i].m1, tbl0[i].disp, tbl0[i].conf, 1'b0);
            q0.push_back(mk(tbl0[i].exp_conf, tbl0[i].exp_dc));
        end

        // Threshold vectors, instance 1
        for (int i = 0; i < 4; i++) begin
            beat1(tbl1[i].m0, 5'($urandom), 8'($urandom));
            beat1(tbl1[i].m1, tbl1[i].disp, tbl1[i].conf);
            q1.push_back(mk(tbl1[i].exp_conf, tbl1[i].exp_dc));
        end

        // D=4 hand groups: all unmasked, then a single unmasked pixel
        for (int i = 0; i < 4; i++) beat2(4'b0000, (i == 3) ? 5'd31 : 5'd1, 8'd255);
        q2.push_back(mk(255, 7905));
        beat2(4'b1111, 5'd5, 8'd9);
        beat2(4'b1111, 5'd5, 8'd9);
        beat2(4'b1111, 5'd5, 8'd9);
        beat2(4'b0111, 5'd2, 8'd255);
        q2.push_back(mk(15, 30));
        drain_all();

        // Backpressure: stall the consumer while four groups stream in
        ordy0 = 1'b0;
        fork
            begin
                for (int g = 0; g < 4; g++) begin
                    ma = 2'(g); mb = 2'(3 - g);
                    d = 5'(g * 7 + 1); c = 8'(60 * g + 30);
                    beat0(ma, 5'd0, 8'd0, 1'b0);
                    beat0(mb, d, c, 1'b0);
                    q0.push_back(model(2, 0, zeros_of(8'(ma), 2) + zeros_of(8'(mb), 2),
                                       int'(d), int'(c)));
                end
            end
            begin
                repeat (10) @(posedge clk);
                @(negedge clk);
                check("bp_in_ready_low", int'(ir0), 0);
                check("bp_out_valid_high", int'(ov0), 1);
                @(posedge clk);
                #1;
                ordy0 = 1'b1;
            end
        join
        drain_all();

        // Flush on the first beat discards it
        beat0(2'b11, 5'd1, 8'd9, 1'b1);
        beat0(2'b00, 5'd4, 8'd50, 1'b0);
        beat0(2'b00, 5'd6, 8'd120, 1'b0);
        q0.push_back(mk(120, 720));
        // Flush alone between beats clears the partial group
        beat0(2'b11, 5'd1, 8'd9, 1'b0);
        flush0 = 1'b1;
        @(posedge clk);
        #1;
        flush0 = 1'b0;
        beat0(2'b00, 5'd1, 8'd9, 1'b0);
        beat0(2'b01, 5'd5, 8'd240, 1'b0);
        q0.push_back(mk(180, 900));
        // Flush on the final beat: no result from that group
        beat0(2'b00, 5'd1, 8'd9, 1'b0);
        beat0(2'b00, 5'd8, 8'd200, 1'b1);
        beat0(2'b10, 5'd1, 8'd9, 1'b0);
        beat0(2'b00, 5'd2, 8'd100, 1'b0);
        q0.push_back(mk(75, 150));
        drain_all();

        // Reset in the middle of a group
        beat0(2'b00, 5'd1, 8'd9, 1'b0);
        #2 reset = 1'b0;
        #1;
        check("midrst_out_valid", int'(ov0), 0);
        check("midrst_conf_out", int'(confo0), 0);
        check("midrst_disp_conf_out", int'(dco0), 0);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        beat0(2'b00, 5'd3, 8'd11, 1'b0);
        beat0(2'b00, 5'd10, 8'd200, 1'b0);
        q0.push_back(mk(200, 2000));
        drain_all();

        // Random groups with gaps and random consumer stalls, instance 0
        done = 1'b0;
        fork
            begin
                for (int g = 0; g < 60; g++) begin
                    ma = 2'($urandom); mb = 2'($urandom);
                    d = 5'($urandom); c = 8'($urandom);
                    beat0(ma, 5'($urandom), 8'($urandom), 1'b0);
                    if ($urandom % 3 == 0) begin
                        repeat (1 + $urandom % 3) begin
                            @(posedge clk);
                            #1;
                        end
                    end
                    beat0(mb, d, c, 1'b0);
                    q0.push_back(model(2, 0, zeros_of(8'(ma), 2) + zeros_of(8'(mb), 2),
                                       int'(d), int'(c)));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    ordy0 = ($urandom % 4) != 0;
                end
                ordy0 = 1'b1;
            end
        join

        // Random groups, instance 2 (D=4)
        for (int g = 0; g < 20; g++) begin
            z = 0;
            for (int b = 0; b < 4; b++) begin
                m4[b] = 4'($urandom);
                z += zeros_of(8'(m4[b]), 4);
            end
            d = 5'($urandom); c = 8'($urandom);
            for (int b = 0; b < 3; b++) beat2(m4[b], 5'($urandom), 8'($urandom));
            beat2(m4[3], d, c);
            q2.push_back(model(4, 0, z, int'(d), int'(c)));
        end
        drain_all();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/weighted_disparity_decimator.md
Name: weighted_disparity_decimator

Overview:
Successor to the disparity-filtering pixel processor. It takes a decimated disparity/confidence stream plus one column of the full-resolution validity mask per beat. For each group of DEC_FACTOR beats it counts the unmasked (zero) mask pixels and scales the confidence by that fraction. It then emits the disparity×confidence product and the scaled confidence to the downstream spatial filter. It adds valid/ready backpressure, a generic DEC_FACTOR, a confidence threshold and a synchronous flush.

Parameters:
DISP_BITS, 5, disparity width
CONF_BITS, 8, confidence width
DEC_FACTOR, 2, decimation factor D; power of two, 2..8
CONF_THRESH, 0, scaled confidence below this is forced to 0

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
flush  in  1  synchronous; discards partial group in accumulator
mask_in  in  DEC_FACTOR  one column of mask pixels; 1 = masked/invalid
disp_in  in  DISP_BITS  disparity for current decimated pixel
conf_in  in  CONF_BITS  raw confidence
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid && in_ready
disp_conf_out  out  DISP_BITS+CONF_BITS  disp × scaled confidence
conf_out  out  CONF_BITS  scaled confidence
out_valid  out  1  output valid
out_ready  in  1  downstream accepts when out_valid && out_ready

Behaviour:
- Reset (reset=0, async): beat counter=0, accumulated count=0, stage-1 and stage-2 valids=0; disp_conf_out=0, conf_out=0, out_valid=0. Reset mid-group discards the partial group; the first beat after release starts a new group.
- Accumulator (stage 0):
  - On each accepted beat, acc += number of 0 bits in mask_in.
  - Beat counter wraps 0..D-1.
  - acc width = clog2(D*D+1).
- Group end: the accepted beat with counter==D-1.
  - Load stage 1 with count=acc+this beat's zeros, and with disp_in/conf_in of this final beat.
  - Clear acc and counter in the same cycle.
- Stage 1 → stage 2 arithmetic:
  - conf_w = (conf × count) >> log2(D*D), truncated. The product width is CONF_BITS+clog2(D*D+1). The result always fits CONF_BITS because count ≤ D*D.
  - If conf_w < CONF_THRESH, conf_w=0.
  - disp_conf = disp × conf_w, full width, no saturation.
  - Result registered into stage 2 (output regs).
- Pipeline control:
  - adv2 = !out_valid || out_ready.
  - adv1 = !s1_valid || adv2.
  - in_ready = adv1 (combinational).
  - Non-final beats are also gated by in_ready, so the group order is strictly preserved.
- Latency: final beat accepted at cycle t → out_valid=1 at t+2 with no stall. Sustained throughput is one result per D beats.
- Output hold: out_valid, disp_conf_out and conf_out are held stable while out_valid && !out_ready.
- flush:
  - Clears acc and counter only; stages 1 and 2 keep their contents.
  - flush together with an accepted beat: the beat is discarded.
  - flush has no effect on in_ready.
- in_valid=0: acc and counter hold; gaps between beats of a group are allowed.
- Simultaneous output pop and group-end push into a full pipe: both occur in the same cycle, with no bubble and no loss.

Test Plan:
- D=2, mask columns 2'b00, 2'b00, disp=10, conf=200, out_ready=1 → count=4, conf_out=200, disp_conf_out=2000, out_valid exactly 2 cycles after the 2nd beat.
- D=2, mask 2'b11, 2'b11, conf=200 → conf_out=0, disp_conf_out=0. Mask 2'b01, 2'b00, disp=10 → count=3, conf_out=150, disp_conf_out=1500.
- CONF_THRESH=100, D=2, mask 2'b11, 2'b10, conf=200 → count=1, conf_w=50 → conf_out=0, disp_conf_out=0. The same group with conf=255 and count=2 → 127, passed through.
- Backpressure: out_ready=0 for 10 cycles while streaming 4 groups → in_ready falls once stages 1 and 2 hold results, and outputs are stable while stalled. On release, all 4 results emerge in order with no duplicates.
- Reset low after 1 of 2 beats, then release and send a full group of zeros with conf=200 → the single output has count=4 (no residue), and all outputs are 0 during reset.
- flush on the 1st beat of a group, then 2 more beats with mask 2'b00 → one result with count=4. A D=4 instance with all 16 mask zeros and conf=255 → conf_out=255.
